// File: rtl/unsat_clause_collector_pkg.sv
// Shared types for the unsat clause collector and the downstream selector.
// Optional feature macro: UNSAT_CLAUSE_COLLECTOR_SAT_FLAG_EN (see top level).
package unsat_clause_collector_pkg;

   localparam int NSAT                  = 3;
   localparam int LITERAL_ADDRESS_WIDTH = 12;
   localparam int CLAUSE_WIDTH          = NSAT * LITERAL_ADDRESS_WIDTH;

   typedef logic [CLAUSE_WIDTH-1:0] clause_t;

   typedef enum logic [1:0] {
      STATE_IDLE = 2'd0,
      STATE_SCAN = 2'd1,
      STATE_DONE = 2'd2
   } state_e;

   // A clause is unsatisfied when none of its literals is currently true.
   function automatic logic clause_is_unsat(input logic [NSAT-1:0] lit_true);
      return lit_true == '0;
   endfunction

endpackage

// File: rtl/unsat_clause_collector_if.sv
// Clause stream, FIFO drain port and status bundle of the collector.
// sat_o exists only when UNSAT_CLAUSE_COLLECTOR_SAT_FLAG_EN is defined.
interface unsat_clause_collector_if
   import unsat_clause_collector_pkg::*;
   #(parameter int COUNT_WIDTH = 12) ();

   // Clause beat transfers on a rising edge where clause_valid_i && clause_ready_o;
   // valid may rise without waiting for ready, and ready never depends on valid.
   logic                   start_i;
   logic                   flush_i;
   logic                   clause_valid_i;
   clause_t                clause_i;
   logic [NSAT-1:0]        lit_true_i;
   logic                   clause_last_i;
   logic                   clause_ready_o;
   logic                   fifo_read_i;
   logic                   fifo_empty_o;
   clause_t                fifo_clause_o;
   logic [COUNT_WIDTH-1:0] unsat_count_o;
   logic                   busy_o;
   logic                   done_o;
   logic [1:0]             state_dbg;
`ifdef UNSAT_CLAUSE_COLLECTOR_SAT_FLAG_EN
   logic                   sat_o;
`endif

   modport master (
      output start_i, flush_i, clause_valid_i, clause_i, lit_true_i, clause_last_i,
             fifo_read_i,
      input  clause_ready_o, fifo_empty_o, fifo_clause_o, unsat_count_o, busy_o,
             done_o, state_dbg
`ifdef UNSAT_CLAUSE_COLLECTOR_SAT_FLAG_EN
      , input sat_o
`endif
   );

   modport slave (
      input  start_i, flush_i, clause_valid_i, clause_i, lit_true_i, clause_last_i,
             fifo_read_i,
      output clause_ready_o, fifo_empty_o, fifo_clause_o, unsat_count_o, busy_o,
             done_o, state_dbg
`ifdef UNSAT_CLAUSE_COLLECTOR_SAT_FLAG_EN
      , output sat_o
`endif
   );

endinterface

// File: rtl/unsat_fifo_fwft.sv
// First-word-fall-through FIFO of unsat clauses; the head entry is visible
// combinationally whenever the FIFO is not empty, and reads as zero when empty.
module unsat_fifo_fwft
   import unsat_clause_collector_pkg::*;
   #(parameter int DEPTH = 64)
   (
      input  logic    clk,
      input  logic    reset,
      input  logic    flush,
      input  logic    push,
      input  clause_t push_data,
      input  logic    pop,
      output logic    full,
      output logic    empty,
      output clause_t head
   );

   localparam int             AW         = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);

   clause_t        mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    occupancy;
   logic           push_en;
   logic           pop_en;

   assign full    = (occupancy == FULL_COUNT);
   assign empty   = (occupancy == '0);
   // Full is judged before any pop this cycle, so a full FIFO never pushes through.
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_en && !flush) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_en, pop_en})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
      end
   end

endmodule

// File: rtl/unsat_clause_collector.sv
// Scans one pass of clauses and queues every clause with no true literal.
// Define UNSAT_CLAUSE_COLLECTOR_SAT_FLAG_EN to add the sat_o solution pulse.
module unsat_clause_collector
   import unsat_clause_collector_pkg::*;
   #(
      parameter int FIFO_DEPTH  = 64,
      parameter int COUNT_WIDTH = 12
   )
   (
      input  logic                     clk,
      input  logic                     reset,
      unsat_clause_collector_if.slave  bus
   );

   localparam logic [1:0] S_IDLE = STATE_IDLE;
   localparam logic [1:0] S_SCAN = STATE_SCAN;
   localparam logic [1:0] S_DONE = STATE_DONE;

   logic [1:0]             state;
   logic [1:0]             state_next;
   logic [COUNT_WIDTH-1:0] unsat_count;
   logic                   fifo_full;
   logic                   fifo_empty;
   clause_t                fifo_head;
   logic                   accept;
   logic                   unsat_beat;

   assign bus.clause_ready_o = (state == S_SCAN) && !fifo_full;
   assign accept             = bus.clause_valid_i && bus.clause_ready_o;
   assign unsat_beat         = accept && clause_is_unsat(bus.lit_true_i);

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (bus.start_i) state_next = S_SCAN;
         S_SCAN:  if (accept && bus.clause_last_i) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_next;
   end

   // Cleared on the start edge; flush leaves it untouched.
   always_ff @(posedge clk) begin
      if (!reset) begin
         unsat_count <= '0;
      end else if (state == S_IDLE && bus.start_i) begin
         unsat_count <= '0;
      end else if (unsat_beat && unsat_count != '1) begin
         unsat_count <= unsat_count + 1'b1;
      end
   end

   unsat_fifo_fwft #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (bus.flush_i),
      .push      (unsat_beat),
      .push_data (bus.clause_i),
      .pop       (bus.fifo_read_i),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   assign bus.fifo_empty_o  = fifo_empty;
   assign bus.fifo_clause_o = fifo_head;
   assign bus.unsat_count_o = unsat_count;
   assign bus.busy_o        = (state != S_IDLE);
   assign bus.done_o        = (state == S_DONE);
   assign bus.state_dbg     = state;

`ifdef UNSAT_CLAUSE_COLLECTOR_SAT_FLAG_EN
   assign bus.sat_o = (state == S_DONE) && (unsat_count == '0);
`endif

endmodule

// File: tb/tb_unsat_clause_collector.sv
// Directed scoreboard bench for unsat_clause_collector: stimulus pushes expected
// pops into exp_q and a negedge monitor compares every FIFO pop against it.
module tb_unsat_clause_collector;
   import unsat_clause_collector_pkg::*;

   logic clk;
   logic reset;
   int   vectors     = 0;
   int   miscompares = 0;
   int   done_seen   = 0;
   logic [CLAUSE_WIDTH-1:0] exp_q[$];

   unsat_clause_collector_if #(.COUNT_WIDTH(12)) bus ();

   unsat_clause_collector #(.FIFO_DEPTH(64), .COUNT_WIDTH(12)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.start_i        = 1'b0;
      bus.flush_i        = 1'b0;
      bus.clause_valid_i = 1'b0;
      bus.clause_i       = '0;
      bus.lit_true_i     = '0;
      bus.clause_last_i  = 1'b0;
      bus.fifo_read_i    = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},  bus.clause_ready_o, 64'd0);
      check({tag, "_empty"},  bus.fifo_empty_o,   64'd1);
      check({tag, "_clause"}, bus.fifo_clause_o,  64'd0);
      check({tag, "_count"},  bus.unsat_count_o,  64'd0);
      check({tag, "_busy"},   bus.busy_o,         64'd0);
      check({tag, "_done"},   bus.done_o,         64'd0);
`ifdef UNSAT_CLAUSE_COLLECTOR_SAT_FLAG_EN
      check({tag, "_sat"},    bus.sat_o,          64'd0);
`endif
   endtask

   task automatic start_pass();
      bus.start_i = 1'b1;
      tick();
      bus.start_i = 1'b0;
      check("start_busy", bus.busy_o, 64'd1);
   endtask

   // Holds one beat until accepted; an unsat beat is expected at the FIFO head later.
   task automatic send_beat(input clause_t c, input logic [NSAT-1:0] lt, input logic last);
      bit ok;
      ok = 1'b0;
      bus.clause_valid_i = 1'b1;
      bus.clause_i       = c;
      bus.lit_true_i     = lt;
      bus.clause_last_i  = last;
      for (int i = 0; i < 200 && !ok; i++) begin
         ok = bus.clause_ready_o;
         if (ok && lt == '0) exp_q.push_back(c);
         tick();
      end
      bus.clause_valid_i = 1'b0;
      bus.clause_last_i  = 1'b0;
      if (!ok) check("beat_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      bus.fifo_read_i = 1'b1;
      for (int i = 0; i < 100 && !bus.fifo_empty_o; i++) tick();
      bus.fifo_read_i = 1'b0;
      check("drain_empty", bus.fifo_empty_o, 64'd1);
      check("scoreboard_residue", exp_q.size(), 64'd0);
   endtask

   // ---------------- scoreboard monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (reset && bus.done_o) done_seen++;
         if (reset && bus.fifo_read_i && !bus.fifo_empty_o) begin
            if (exp_q.size() == 0) check("pop_unexpected", bus.fifo_clause_o, 64'd0 - 64'd1);
            else                   check("pop_order", bus.fifo_clause_o, exp_q.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int k;
      int done_before;
      clause_t base;

      idle_inputs();
      reset = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      check("reset_occupancy", dut.u_fifo.occupancy, 64'd0);
      reset = 1'b1;
      tick();

      // Single unsat clause
      done_before = done_seen;
      start_pass();
      check("scan_ready", bus.clause_ready_o, 64'd1);
      send_beat(36'h666666666, 3'b000, 1'b1);
      check("single_empty", bus.fifo_empty_o, 64'd0);
      check("single_clause", bus.fifo_clause_o, 64'h666666666);
      check("single_count", bus.unsat_count_o, 64'd1);
      check("single_done", bus.done_o, 64'd1);
      tick();
      check("single_done_low", bus.done_o, 64'd0);
      check("single_idle", bus.busy_o, 64'd0);
      check("single_done_pulses", done_seen - done_before, 64'd1);
      drain();

      // Mixed stream: even clauses unsat, odd clauses sat
      start_pass();
      for (int i = 0; i < 20; i++)
         send_beat(clause_t'(i), (i % 2 == 0) ? 3'b000 : 3'b001, i == 19);
      check("mixed_count", bus.unsat_count_o, 64'd10);
      check("mixed_done", bus.done_o, 64'd1);
      drain();

      // Full backpressure with 70 unsat beats
      base = 36'h100;
      start_pass();
      k = 0;
      bus.clause_valid_i = 1'b1;
      bus.lit_true_i     = '0;
      bus.clause_last_i  = 1'b0;
      for (int cyc = 0; cyc < 200 && k < 64; cyc++) begin
         bus.clause_i = base + clause_t'(k);
         if (bus.clause_ready_o) begin
            exp_q.push_back(bus.clause_i);
            k++;
         end
         tick();
      end
      bus.clause_i = base + clause_t'(k);
      check("full_ready_low", bus.clause_ready_o, 64'd0);
      check("full_occupancy", dut.u_fifo.occupancy, 64'd64);
      repeat (3) tick();
      check("full_ready_held", bus.clause_ready_o, 64'd0);
      bus.fifo_read_i = 1'b1;
      check("no_push_through_ready", bus.clause_ready_o, 64'd0);
      tick();
      bus.fifo_read_i = 1'b0;
      check("pop_only_occupancy", dut.u_fifo.occupancy, 64'd63);
      check("ready_after_pop", bus.clause_ready_o, 64'd1);
      exp_q.push_back(bus.clause_i);
      k++;
      tick();
      check("refill_ready_low", bus.clause_ready_o, 64'd0);
      check("refill_occupancy", dut.u_fifo.occupancy, 64'd64);
      bus.fifo_read_i = 1'b1;
      for (int cyc = 0; cyc < 300 && k < 70; cyc++) begin
         bus.clause_i      = base + clause_t'(k);
         bus.clause_last_i = (k == 69);
         if (bus.clause_ready_o) begin
            exp_q.push_back(bus.clause_i);
            k++;
         end
         tick();
      end
      bus.clause_valid_i = 1'b0;
      bus.clause_last_i  = 1'b0;
      check("backpressure_beats", k, 64'd70);
      check("backpressure_count", bus.unsat_count_o, 64'd70);
      drain();

      // Simultaneous push and pop at 32 entries
      start_pass();
      for (int i = 0; i < 32; i++) send_beat(36'h200 + clause_t'(i), 3'b000, 1'b0);
      check("half_occupancy", dut.u_fifo.occupancy, 64'd32);
      bus.fifo_read_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         send_beat(36'h300 + clause_t'(i), 3'b000, 1'b0);
         check("pushpop_occupancy", dut.u_fifo.occupancy, 64'd32);
      end
      bus.fifo_read_i = 1'b0;
      send_beat(36'h3ff, 3'b100, 1'b1);
      check("pushpop_count", bus.unsat_count_o, 64'd42);
      drain();
      bus.fifo_read_i = 1'b1;
      tick();
      bus.fifo_read_i = 1'b0;
      check("empty_read_empty", bus.fifo_empty_o, 64'd1);
      check("empty_read_occupancy", dut.u_fifo.occupancy, 64'd0);
      check("empty_read_clause", bus.fifo_clause_o, 64'd0);

      // Flush with a simultaneous push, then reset mid-pass
      start_pass();
      for (int i = 0; i < 5; i++) send_beat(36'h500 + clause_t'(i), 3'b000, 1'b0);
      check("preflush_occupancy", dut.u_fifo.occupancy, 64'd5);
      bus.flush_i        = 1'b1;
      bus.clause_valid_i = 1'b1;
      bus.clause_i       = 36'h5ff;
      bus.lit_true_i     = '0;
      tick();
      bus.flush_i        = 1'b0;
      bus.clause_valid_i = 1'b0;
      exp_q.delete();
      check("flush_empty", bus.fifo_empty_o, 64'd1);
      check("flush_occupancy", dut.u_fifo.occupancy, 64'd0);
      check("flush_clause", bus.fifo_clause_o, 64'd0);
      check("flush_keeps_scan", bus.busy_o, 64'd1);
      send_beat(36'h600, 3'b000, 1'b0);
      check("postflush_head", bus.fifo_clause_o, 64'h600);
      reset = 1'b0;
      tick();
      exp_q.delete();
      check_reset_outputs("midpass_reset");
      reset = 1'b1;
      tick();
      check("after_reset_idle", bus.busy_o, 64'd0);

`ifdef UNSAT_CLAUSE_COLLECTOR_SAT_FLAG_EN
      start_pass();
      for (int i = 0; i < 8; i++) send_beat(36'h700 + clause_t'(i), 3'b010, i == 7);
      check("sat_pass_done", bus.done_o, 64'd1);
      check("sat_pass_sat", bus.sat_o, 64'd1);
      tick();
      check("sat_pulse_end", bus.sat_o, 64'd0);
      start_pass();
      send_beat(36'h800, 3'b001, 1'b0);
      send_beat(36'h801, 3'b000, 1'b0);
      send_beat(36'h802, 3'b111, 1'b1);
      check("unsat_pass_done", bus.done_o, 64'd1);
      check("unsat_pass_sat", bus.sat_o, 64'd0);
      drain();
`endif

      repeat (2) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/unsat_clause_collector.md
# unsat_clause_collector

Streams clauses from the clause-memory scanner and evaluates each one against its per-literal truth flags. Every clause with no true literal is pushed into an internal first-word-fall-through FIFO. The downstream unsat clause selector drains that FIFO through its fifo_empty / fifo_clause / read interface. The collector sits between the assignment/clause evaluation pipeline and the selector, and runs one pass per start request from the search controller.

## Interface
- NSAT, 3, literals per clause
- LITERAL_ADDRESS_WIDTH, 12, bits per literal
- FIFO_DEPTH, 64, FIFO entries, power of two
- COUNT_WIDTH, 12, width of the unsat counter for one pass
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- start_i  in  1  begin a pass; sampled only in IDLE
- flush_i  in  1  empty the FIFO
- clause_valid_i  in  1  clause beat valid
- clause_i  in  NSAT*LITERAL_ADDRESS_WIDTH  clause literals
- lit_true_i  in  NSAT  bit k = literal k currently true
- clause_last_i  in  1  final clause of the pass
- clause_ready_o  out  1  beat accepted when valid && ready
- fifo_read_i  in  1  pop request from the selector
- fifo_empty_o  out  1  FIFO empty
- fifo_clause_o  out  NSAT*LITERAL_ADDRESS_WIDTH  head entry, valid while !fifo_empty_o
- unsat_count_o  out  COUNT_WIDTH  unsat clauses found this pass
- busy_o  out  1  FSM not in IDLE
- done_o  out  1  one-cycle pulse at end of pass

## Operation
- FSM states are IDLE, SCAN and DONE.
  - IDLE→SCAN on start_i. Entering SCAN clears unsat_count_o.
  - SCAN→DONE on an accepted beat with clause_last_i=1.
  - DONE→IDLE unconditionally after one cycle, with done_o=1.
- start_i is ignored outside IDLE.
- clause_ready_o = (state==SCAN) && !full.
- A clause is unsat when lit_true_i==0. An accepted unsat beat pushes clause_i and increments unsat_count_o. The counter saturates at 2^COUNT_WIDTH−1.
- An accepted sat beat is consumed with no push.
- Pop occurs when fifo_read_i && !fifo_empty_o. A read while empty is ignored, with no pointer or count change.
- Push and pop in the same cycle are both performed and the occupancy is unchanged.
- Full is evaluated before the pop, so there is no push-through when full. Ready stays low for that cycle.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Occupancy is a separate counter, log2(FIFO_DEPTH)+1 bits wide.
- flush_i empties the FIFO on the next edge. It overrides any push or pop in the same cycle and does not change the FSM state or the counter.
- Reset mid-pass returns the block to IDLE and discards the FIFO contents and the counter.

## Timing
- Reset values:
  - clause_ready_o=0, fifo_empty_o=1, fifo_clause_o=0, unsat_count_o=0, busy_o=0, done_o=0.
  - The FSM is in IDLE and the pointers and occupancy are 0.
- start_i high at edge N puts the FSM in SCAN after N, so clause_ready_o can be high in cycle N+1.
- An unsat beat accepted at edge N gives fifo_empty_o=0 and fifo_clause_o=clause in cycle N+1. unsat_count_o updates at the same edge N.
- A pop at edge N presents the next head entry in cycle N+1, or raises fifo_empty_o.
- The last beat accepted at edge N gives done_o=1 in cycle N+1 and busy_o=0 in cycle N+2.
- Throughput is one clause per cycle while not full.

## Configuration
- UNSAT_CLAUSE_COLLECTOR_SAT_FLAG_EN
- When defined:
  - An extra output port, sat_o (1 bit), is added.
  - sat_o pulses coincident with done_o when the pass ends with unsat_count_o==0, meaning a solution was found.
  - sat_o resets to 0.
- When undefined, the port and its logic are absent.

## Structure
- The shared package holds:
  - the clause_t typedef (NSAT*LITERAL_ADDRESS_WIDTH bits)
  - the FSM state enum
  - NSAT and LITERAL_ADDRESS_WIDTH defaults, shared with the selector
- One sub-module, unsat_fifo_fwft, holds the storage array, pointers, occupancy, full/empty and flush. The FSM, evaluation and counter stay in the top level.

## Test plan
- Single unsat clause:
  - Stimulus: reset, start, one beat with clause 0x666666666, lit_true=0 and last=1.
  - Required response: next cycle fifo_empty_o=0, fifo_clause_o=0x666666666, unsat_count_o=1, and done_o pulses once.
- Mixed stream:
  - Stimulus: 20 beats with clause_i=i and lit_true=0 for even i, 1 for odd i.
  - Required response: the FIFO pops 0,2,…,18 in order and unsat_count_o=10.
- Full backpressure:
  - Stimulus: 70 unsat beats with no reads.
  - Required response: clause_ready_o drops after 64 pushes.
  - Then read one entry: ready rises and a push resumes on the next edge.
- Simultaneous push/pop at 32 entries:
  - Required response: occupancy stays at 32 and the order is preserved.
  - A read when empty leaves fifo_empty_o=1.
- Flush and mid-pass reset:
  - Stimulus: flush with 5 entries and a push in the same cycle.
  - Required response: the FIFO is empty.
  - Then reset low during SCAN: all outputs return to their reset values.
- With UNSAT_CLAUSE_COLLECTOR_SAT_FLAG_EN:
  - Stimulus: a pass of 8 beats, all with lit_true≠0.
  - Required response: sat_o=1 together with done_o.
  - A pass with one unsat clause gives sat_o=0.
